capture_page_ctrl: RTL
======================

CAPTURE_PAGE_CTRL -- requirements
Module: capture_page_ctrl

Interface
REQ-001 SHALL have parameters: SAMPLE_PACKET_WIDTH, default 32, packet/memory word width; PAGE_ADDR_WIDTH, default 8, giving 256 words per page; PAGE_SEL_WIDTH, default 2, giving 4 pages.
REQ-002 SHALL have ports:
  clk  in  1  sole clock; all logic on posedge.
  reset  in  1  asynchronous, active-high.
  packet_in  in  SAMPLE_PACKET_WIDTH  sample packet from the capture engine.
  packet_we  in  1  packet_in valid this cycle.
  capture_start  in  1  capture start pulse.
  capture_idle  in  1  capture engine idle level.
  page_full  out  1  no free page; capture engine must stall.
  overflow  out  1  sticky; a packet was dropped.
  mem_addr  out  PAGE_SEL_WIDTH+PAGE_ADDR_WIDTH  single-port RAM address, {page, offset}.
  mem_wdata  out  SAMPLE_PACKET_WIDTH  RAM write data.
  mem_we  out  1  RAM write strobe.
  mem_rdata  in  SAMPLE_PACKET_WIDTH  RAM read data, 1-cycle synchronous read.
  rd_page_valid  out  1  oldest closed page is available to the host.
  rd_page_num  out  PAGE_SEL_WIDTH  index of that page.
  rd_page_words  out  PAGE_ADDR_WIDTH+1  valid word count of that page (1..256).
  rd_req  in  1  host read request; held until rd_ack.
  rd_addr  in  PAGE_ADDR_WIDTH  word offset within rd_page_num.
  rd_ack  out  1  read request accepted this cycle.
  rd_data  out  SAMPLE_PACKET_WIDTH  read data.
  rd_data_valid  out  1  rd_data valid.
  rd_page_release  in  1  host finished with the current page.

Function
REQ-003 SHALL track a per-page state of FREE, FILLING or READY, plus a write pointer (wr_page, wr_offset) and a read pointer rd_ptr that advance modulo the page count.
REQ-004 SHALL accept packet_we at cycle T when the page at wr_page is FREE or FILLING, and drive mem_we=1, mem_addr={wr_page,wr_offset} and mem_wdata=packet_in at T+1.
REQ-005 SHALL, when a page's 256th word is written (wr_offset=255), mark that page READY with word count 256, set wr_offset=0 and advance wr_page.
REQ-006 SHALL, on a rising edge of capture_idle with wr_offset!=0, close the partial page as READY with count wr_offset, then advance wr_page and clear wr_offset.
REQ-007 SHALL register page_full=1 whenever the page at wr_page is READY, i.e. no free page is available.
REQ-008 SHALL drop any packet_we seen while page_full=1, with no memory write, and set overflow=1.
REQ-009 SHALL clear overflow on capture_start; page states and pointers are unaffected.
REQ-010 SHALL drive rd_page_valid=1 when page rd_ptr is READY, with rd_page_num=rd_ptr and rd_page_words equal to that page's count; pages are presented in write order.
REQ-011 SHALL treat rd_page_release while rd_page_valid=1 as: page rd_ptr becomes FREE and rd_ptr advances; rd_page_release while rd_page_valid=0 SHALL be ignored.
REQ-012 SHALL arbitrate the RAM port with capture writes having priority: rd_ack=1 (combinational) at cycle T only if rd_req=1, rd_page_valid=1 and packet_we=0 (or packet_we is being dropped).
REQ-013 SHALL, for a read accepted at T, drive mem_addr={rd_page_num,rd_addr} with mem_we=0 at T+1, and rd_data=mem_rdata with rd_data_valid=1 at T+2.
REQ-014 SHALL apply a release and a page close in the same cycle both; if the released page is wr_page, page_full SHALL deassert the next cycle.
REQ-015 SHALL hold page_full at 1 if a close and a release in the same cycle leave no FREE page at wr_page.

Reset
REQ-016 SHALL, while reset=1 (asynchronous), set all pages FREE, wr_page=wr_offset=rd_ptr=0, and drive every output (page_full, overflow, mem_we, mem_addr, mem_wdata, rd_page_valid, rd_page_num, rd_page_words, rd_ack, rd_data, rd_data_valid) to 0.
REQ-017 SHALL discard any in-flight write or read on reset, with no mem_we or rd_data_valid after reset deasserts unless newly requested.

Verification
REQ-018 Page fill: 256 consecutive packet_we with data 0..255 -> mem_we at addresses 0x000..0x0FF one cycle later; rd_page_valid=1, rd_page_num=0, rd_page_words=256.
REQ-019 Partial flush: 10 packets, then capture_idle 0->1 -> page 0 READY with rd_page_words=10, and the next packet writes to address 0x100.
REQ-020 Full/overflow: 1024 packets with no release -> page_full=1 after the 1024th; packet 1025 produces no mem_we and overflow=1; one rd_page_release -> page_full=0 next cycle; capture_start -> overflow=0.
REQ-021 Arbitration: rd_req with rd_addr=5 held during a write burst -> rd_ack=0 throughout the burst; rd_ack=1 in the first cycle with packet_we=0; rd_data equals word 5 two cycles later with rd_data_valid=1.
REQ-022 Reset mid-operation: assert reset at offset 100 of page 1 with a read pending -> all outputs 0 immediately; after release, the first packet writes to address 0x000.

Source files
------------

// File: rtl/capture_page_ctrl.sv
// Paged capture buffer controller: fills a ring of RAM pages from the capture
// engine and hands closed pages to the host in write order over a shared RAM port.
module capture_page_ctrl #(
  parameter int SAMPLE_PACKET_WIDTH = 32,
  parameter int PAGE_ADDR_WIDTH     = 8,
  parameter int PAGE_SEL_WIDTH      = 2
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic [SAMPLE_PACKET_WIDTH-1:0]          packet_in,
  input  logic                                    packet_we,
  input  logic                                    capture_start,
  input  logic                                    capture_idle,
  output logic                                    page_full,
  output logic                                    overflow,
  output logic [PAGE_SEL_WIDTH+PAGE_ADDR_WIDTH-1:0] mem_addr,
  output logic [SAMPLE_PACKET_WIDTH-1:0]          mem_wdata,
  output logic                                    mem_we,
  input  logic [SAMPLE_PACKET_WIDTH-1:0]          mem_rdata,
  output logic                                    rd_page_valid,
  output logic [PAGE_SEL_WIDTH-1:0]               rd_page_num,
  output logic [PAGE_ADDR_WIDTH:0]                rd_page_words,
  input  logic                                    rd_req,
  input  logic [PAGE_ADDR_WIDTH-1:0]              rd_addr,
  output logic                                    rd_ack,
  output logic [SAMPLE_PACKET_WIDTH-1:0]          rd_data,
  output logic                                    rd_data_valid,
  input  logic                                    rd_page_release
);

  localparam int PAGES = 1 << PAGE_SEL_WIDTH;
  localparam int CW    = PAGE_ADDR_WIDTH + 1;

  typedef enum logic [1:0] {FREE, FILLING, READY} pageState_t;

  pageState_t                pageState     [PAGES];
  pageState_t                pageStateNext [PAGES];
  logic [CW-1:0]             pageCount     [PAGES];
  logic [CW-1:0]             pageCountNext [PAGES];
  logic [PAGE_SEL_WIDTH-1:0] wrPage, wrPageNext, rdPtr, rdPtrNext;
  logic [PAGE_ADDR_WIDTH-1:0] wrOffset, wrOffsetNext;
  logic [CW-1:0]             effCount;
  logic                      idlePrev, readPending, rdDataValid;
  logic                      accept, drop, rdAccept, idleRise, relPage, fullNext, pageDone;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pageState   <= '{default: FREE};
      pageCount   <= '{default: '0};
      wrPage      <= '0;
      wrOffset    <= '0;
      rdPtr       <= '0;
      idlePrev    <= 1'b0;
      page_full   <= 1'b0;
      overflow    <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      readPending <= 1'b0;
      rdDataValid <= 1'b0;
    end else begin
      pageState   <= pageStateNext;
      pageCount   <= pageCountNext;
      wrPage      <= wrPageNext;
      wrOffset    <= wrOffsetNext;
      rdPtr       <= rdPtrNext;
      idlePrev    <= capture_idle;
      page_full   <= fullNext;
      overflow    <= (overflow & ~capture_start) | drop;
      mem_we      <= accept;
      readPending <= rdAccept;
      rdDataValid <= readPending;
      if (accept) begin
        mem_addr  <= {wrPage, wrOffset};
        mem_wdata <= packet_in;
      end else if (rdAccept) begin
        mem_addr  <= {rdPtr, rd_addr};
      end
    end
  end

  // Next-state logic
  always_comb begin
    accept        = packet_we && !page_full;
    drop          = packet_we && page_full;
    rdAccept      = rd_req && rd_page_valid && !accept;
    idleRise      = capture_idle && !idlePrev;
    relPage       = rd_page_release && rd_page_valid;
    effCount      = {1'b0, wrOffset} + CW'(accept);
    pageDone      = accept && (wrOffset == '1);
    pageStateNext = pageState;
    pageCountNext = pageCount;
    wrPageNext    = wrPage;
    wrOffsetNext  = wrOffset;
    rdPtrNext     = rdPtr;
    if (accept) begin
      pageStateNext[wrPage] = FILLING;
      wrOffsetNext          = wrOffset + 1'b1;
    end
    // A packet landing in the same cycle as the idle edge is counted in the closed page.
    if (pageDone || (idleRise && effCount != '0)) begin
      pageStateNext[wrPage] = READY;
      pageCountNext[wrPage] = effCount;
      wrPageNext            = wrPage + 1'b1;
      wrOffsetNext          = '0;
    end
    if (relPage) begin
      pageStateNext[rdPtr] = FREE;
      rdPtrNext            = rdPtr + 1'b1;
    end
    fullNext = (pageStateNext[wrPageNext] == READY);
  end

  // Output logic
  always_comb begin
    rd_page_valid = (pageState[rdPtr] == READY);
    rd_page_num   = rdPtr;
    rd_page_words = rd_page_valid ? pageCount[rdPtr] : '0;
    rd_ack        = rdAccept;
    rd_data_valid = rdDataValid;
    rd_data       = rdDataValid ? mem_rdata : '0;
  end

endmodule
